// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: opcodes, immediate
// formats, ALU operation codes and the decoded control bundle.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_ctrl_t   alu_ctrl;
        logic        alu_src;
        logic        illegal;
    } ctrl_t;

    // alt selects SUB / SRA, the funct7[5] variants of ADD / SRL.
    function automatic alu_ctrl_t alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I decoder: control bundle, illegal detection and the
// sign-extended immediate for one instruction word.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm_ext
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    imm_src_t   imm_src;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        case (opcode)
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_PASSB;
                imm_src        = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OPC_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
            end
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                // Only the shifts constrain funct7; it is immediate bits elsewhere.
                if ((funct3 == 3'b001 && funct7 != FUNCT7_BASE) ||
                    (funct3 == 3'b101 && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT))
                    ctrl.illegal = 1'b1;
                else
                    ctrl.alu_ctrl = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                if (funct7 == FUNCT7_BASE ||
                    (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
                    ctrl.alu_ctrl = alu_op(funct3, funct7[5]);
                else
                    ctrl.illegal = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: ctrl.illegal = 1'b1;
        endcase
        if (ctrl.illegal) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
        end
    end

    always_comb begin
        case (imm_src)
            IMM_S:   imm_ext = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm_ext = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:   imm_ext = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:   imm_ext = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm_ext = XLEN'($signed(instr[31:20]));
        endcase
    end

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage with valid/ready handshakes on both sides and a two-entry
// (main + skid) buffer so the upstream ready can come straight from a flop.
module decode_stage_hs
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_f,
    output logic                  ready_d,
    input  logic [31:0]           instr_f,
    input  logic [XLEN-1:0]       pc_f,
    input  logic [XLEN-1:0]       pc_plus4_f,
    input  logic                  flush_d,
    output logic                  valid_d,
    input  logic                  ready_e,
    output logic [4:0]            rs1_d,
    output logic [4:0]            rs2_d,
    output logic [4:0]            rd_d,
    output logic [XLEN-1:0]       imm_ext_d,
    output logic                  reg_write_d,
    output logic [1:0]            result_src_d,
    output logic                  mem_write_d,
    output logic                  jump_d,
    output logic                  branch_d,
    output logic [ALU_CTRL_W-1:0] alu_control_d,
    output logic                  alu_src_d,
    output logic                  illegal_d,
    output logic [XLEN-1:0]       pc_d,
    output logic [XLEN-1:0]       pc_plus4_d
);

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } slot_t;

    slot_t main_q, main_d;
    slot_t skid_q, skid_d;
    slot_t incoming;
    logic  in_fire;
    logic  main_free;
    ctrl_t ctrl;

    // Handshake: a word moves across an interface on a clock edge where both
    // valid and ready are high; valid never waits on ready, and a presented
    // word holds stable until taken. ready_d is high whenever the skid is empty.
    assign ready_d   = ~skid_q.valid;
    assign in_fire   = valid_f & ready_d;
    assign main_free = ~main_q.valid | ready_e;

    always_comb begin
        incoming.valid = 1'b1;
        incoming.instr = instr_f;
        incoming.pc    = pc_f;
        incoming.pc4   = pc_plus4_f;
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush_d) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (main_free) begin
            // The skid always holds the older word, so it refills main first.
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (in_fire) begin
                main_d = incoming;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = incoming;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    decode_ctrl #(.XLEN(XLEN)) u_decode_ctrl (
        .instr   (main_q.instr),
        .ctrl    (ctrl),
        .imm_ext (imm_ext_d)
    );

    assign valid_d       = main_q.valid;
    assign rs1_d         = main_q.instr[19:15];
    assign rs2_d         = main_q.instr[24:20];
    assign rd_d          = main_q.instr[11:7];
    assign pc_d          = main_q.pc;
    assign pc_plus4_d    = main_q.pc4;
    assign reg_write_d   = valid_d & ctrl.reg_write;
    assign result_src_d  = valid_d ? ctrl.result_src : RES_ALU;
    assign mem_write_d   = valid_d & ctrl.mem_write;
    assign jump_d        = valid_d & ctrl.jump;
    assign branch_d      = valid_d & ctrl.branch;
    assign alu_control_d = valid_d ? ALU_CTRL_W'(ctrl.alu_ctrl) : '0;
    assign alu_src_d     = valid_d & ctrl.alu_src;
    assign illegal_d     = valid_d & ctrl.illegal;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: directed handshake scenarios plus random traffic,
// scored against an instruction-level RV32I decode model.
module tb_decode_stage_hs;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_f;
    logic            ready_d;
    logic [31:0]     instr_f;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic            flush_d;
    logic            valid_d;
    logic            ready_e;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] imm_ext_d;
    logic            reg_write_d;
    logic [1:0]      result_src_d;
    logic            mem_write_d;
    logic            jump_d, branch_d;
    logic [3:0]      alu_control_d;
    logic            alu_src_d;
    logic            illegal_d;
    logic [XLEN-1:0] pc_d, pc_plus4_d;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        jmp;
        logic        br;
        logic [3:0]  alu;
        logic        asrc;
        logic        ill;
    } vec_t;

    typedef struct packed {
        vec_t v;
        logic imm_chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_stall = 1'b0;
    vec_t prev_out;

    logic [6:0] op_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    always #5 clk = ~clk;

    decode_stage_hs #(.XLEN(XLEN), .ALU_CTRL_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_f       (valid_f),
        .ready_d       (ready_d),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .flush_d       (flush_d),
        .valid_d       (valid_d),
        .ready_e       (ready_e),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rd_d          (rd_d),
        .imm_ext_d     (imm_ext_d),
        .reg_write_d   (reg_write_d),
        .result_src_d  (result_src_d),
        .mem_write_d   (mem_write_d),
        .jump_d        (jump_d),
        .branch_d      (branch_d),
        .alu_control_d (alu_control_d),
        .alu_src_d     (alu_src_d),
        .illegal_d     (illegal_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d)
    );

    // Reference: what an RV32I decoder must report for one instruction word.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   s;
        int   alu_tab [8];
        logic [6:0] f7;
        logic [2:0] f3;
        alu_tab = '{0, 7, 5, 6, 4, 8, 3, 2};
        s  = int'(ins);
        f7 = ins[31:25];
        f3 = ins[14:12];
        e  = '0;
        e.v.rs1 = ins[19:15];
        e.v.rs2 = ins[24:20];
        e.v.rd  = ins[11:7];
        e.v.pc  = pc;
        e.v.pc4 = pc + 32'd4;
        e.imm_chk = 1'b1;
        case (ins[6:0])
            7'h37: begin e.v.rw = 1; e.v.asrc = 1; e.v.alu = 4'd10; e.v.imm = ins & 32'hFFFF_F000; end
            7'h17: begin e.v.rw = 1; e.v.asrc = 1; e.v.imm = ins & 32'hFFFF_F000; end
            7'h6F: begin
                e.v.rw = 1; e.v.jmp = 1; e.v.asrc = 1; e.v.rsrc = 2'd2;
                e.v.imm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                          (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67: begin e.v.rw = 1; e.v.jmp = 1; e.v.asrc = 1; e.v.rsrc = 2'd2; e.v.imm = 32'(s >>> 20); end
            7'h63: begin
                e.v.br = 1; e.v.alu = 4'd1;
                e.v.imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                          (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h03: begin e.v.rw = 1; e.v.asrc = 1; e.v.rsrc = 2'd1; e.v.imm = 32'(s >>> 20); end
            7'h23: begin e.v.mw = 1; e.v.asrc = 1; e.v.imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]); end
            7'h13: begin
                e.v.rw = 1; e.v.asrc = 1; e.v.imm = 32'(s >>> 20);
                if (f3 == 3'd1 && f7 != 7'h00) e.v.ill = 1;
                else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) e.v.ill = 1;
                else if (f3 == 3'd5 && f7 == 7'h20) e.v.alu = 4'd9;
                else e.v.alu = 4'(alu_tab[f3]);
            end
            7'h33: begin
                e.v.rw = 1; e.imm_chk = 0;
                if (f7 == 7'h00) e.v.alu = 4'(alu_tab[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.v.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.v.alu = 4'd9;
                else e.v.ill = 1;
            end
            7'h0F, 7'h73: e.imm_chk = 0;
            default: begin e.v.ill = 1; e.imm_chk = 0; end
        endcase
        if (e.v.ill) begin
            e.v.rw = 0;
            e.v.mw = 0;
        end
        return e;
    endfunction

    function automatic vec_t dut_out();
        vec_t o;
        o.rs1 = rs1_d; o.rs2 = rs2_d; o.rd = rd_d; o.imm = imm_ext_d;
        o.pc = pc_d; o.pc4 = pc_plus4_d; o.rw = reg_write_d; o.rsrc = result_src_d;
        o.mw = mem_write_d; o.jmp = jump_d; o.br = branch_d; o.alu = alu_control_d;
        o.asrc = alu_src_d; o.ill = illegal_d;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = op_tab[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: present one cycle of inputs; record acceptance/flush at mid-cycle.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic re);
        logic [31:0] pc;
        pc         = $urandom & 32'hFFFF_FFFC;
        valid_f    = v;
        instr_f    = ins;
        pc_f       = pc;
        pc_plus4_f = pc + 32'd4;
        flush_d    = fl;
        ready_e    = re;
        @(negedge clk);
        if (reset) begin
            if (flush_d) exp_q.delete();
            else if (valid_f && ready_d) exp_q.push_back(ref_model(instr_f, pc_f));
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: score every output transfer and check hold-stability under stall.
    always @(negedge clk) begin
        vec_t cur, diff;
        exp_t e;
        if (reset) begin
            cur = dut_out();
            if (prev_stall) begin
                n_vec++;
                if (!valid_d || cur !== prev_out) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b %0h expected %0h", valid_d, cur, prev_out);
                end
            end
            if (valid_d && ready_e && !flush_d) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got %0h expected nothing", cur);
                end else begin
                    e = exp_q.pop_front();
                    diff = cur ^ e.v;
                    if (!e.imm_chk) diff.imm = '0;
                    if (diff != '0) begin
                        n_err++;
                        $display("FAIL decode: got %0h expected %0h", cur, e.v);
                    end
                end
            end
            prev_stall = valid_d && !ready_e && !flush_d;
            prev_out   = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        reset      = 1'b0;
        valid_f    = 1'b1;
        instr_f    = 32'h0051_0093;
        pc_f       = 32'h100;
        pc_plus4_f = 32'h104;
        flush_d    = 1'b0;
        ready_e    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(valid_d), 32'd0);
        check("reset_ready", 32'(ready_d), 32'd1);
        check("reset_ctrl", 32'({reg_write_d, result_src_d, mem_write_d, jump_d, branch_d,
                                 alu_control_d, alu_src_d, illegal_d}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        step(1, 32'h0051_0093, 0, 1);
        check("addi_latency", 32'(valid_d), 32'd1);
        check("addi_fields", {17'd0, rs1_d, rd_d, alu_control_d, alu_src_d, reg_write_d},
              {17'd0, 5'd2, 5'd1, 4'd0, 1'b1, 1'b1});
        check("addi_imm", imm_ext_d, 32'd5);

        step(1, 32'h4020_81B3, 0, 1);
        check("sub_alu", {27'd0, alu_control_d, alu_src_d}, {27'd0, 4'd1, 1'b0});
        step(1, 32'h0051_2423, 0, 1);
        check("sw_imm", imm_ext_d, 32'd8);
        check("sw_wr", {30'd0, mem_write_d, reg_write_d}, {30'd0, 1'b1, 1'b0});
        step(0, 32'h0, 0, 1);

        step(1, 32'hFE00_0EE3, 0, 0);
        step(1, 32'h1234_52B7, 0, 0);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);
        check("skid_full_ready", 32'(ready_d), 32'd0);
        check("beq_held", {30'd0, valid_d, branch_d}, {30'd0, 1'b1, 1'b1});
        check("beq_imm", imm_ext_d, 32'hFFFF_FFFC);
        step(0, 32'h0, 0, 1);
        check("lui_imm", imm_ext_d, 32'h1234_5000);
        check("lui_alu", 32'(alu_control_d), 32'd10);
        check("ready_back", 32'(ready_d), 32'd1);
        step(0, 32'h0, 0, 1);

        step(1, rand_instr(), 0, 0);
        step(1, rand_instr(), 0, 0);
        check("pre_flush_ready", 32'(ready_d), 32'd0);
        step(1, rand_instr(), 1, 0);
        check("flush_state", {30'd0, valid_d, ready_d}, {30'd0, 1'b0, 1'b1});
        step(0, 32'h0, 0, 1);

        step(1, 32'h0080_00EF, 0, 1);
        check("jal", {29'd0, jump_d, result_src_d}, {29'd0, 1'b1, 2'b10});
        check("jal_imm", imm_ext_d, 32'd8);
        step(1, 32'h0000_0000, 0, 1);
        check("illegal", {29'd0, illegal_d, reg_write_d, mem_write_d}, {29'd0, 3'b100});
        step(0, 32'h0, 0, 1);

        step(1, rand_instr(), 0, 0);
        step(1, rand_instr(), 0, 0);
        #2;
        exp_q.delete();
        reset   = 1'b0;
        valid_f = 1'b0;
        #1;
        check("async_reset", {30'd0, valid_d, ready_d}, {30'd0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", {30'd0, valid_d, ready_d}, {30'd0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
Parametrised successor of the 5-stage decode stage. It replaces the stall/flush-enable pipeline register with a valid/ready handshake on both sides and a 2-entry skid buffer, so decode runs at full throughput with a registered upstream ready. Decoding covers full RV32I: I/S/B/U/J immediates, a 4-bit ALU control and illegal-instruction detection. It sits between the fetch and execute stages.

Parameters:
XLEN, 32, datapath/PC width; immediates are sign-extended to XLEN.
ALU_CTRL_W, 4, width of alu_control_d.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
valid_f  in  1  fetch presents an instruction
ready_d  out  1  decode can accept; registered
instr_f  in  32  instruction word
pc_f  in  XLEN  PC of instr_f
pc_plus4_f  in  XLEN  PC+4 of instr_f
flush_d  in  1  discard all held and incoming instructions
valid_d  out  1  decoded outputs valid
ready_e  in  1  execute accepts
rs1_d, rs2_d, rd_d  out  5 each  register fields
imm_ext_d  out  XLEN  extended immediate
reg_write_d  out  1  write rd
result_src_d  out  2  00 ALU, 01 mem, 10 PC+4
mem_write_d  out  1  store
jump_d, branch_d  out  1 each  jal/jalr, conditional branch
alu_control_d  out  ALU_CTRL_W  ALU operation
alu_src_d  out  1  ALU B operand = immediate
illegal_d  out  1  unsupported opcode/funct
pc_d, pc_plus4_d  out  XLEN  forwarded PCs

Behaviour:
- Transfer in when valid_f and ready_d; transfer out when valid_d and ready_e.
- Storage: main register (drives outputs) and skid register. Each holds instr, pc, pc+4 and a valid bit.
- Reset (asynchronous, reset=0): both valid bits 0, all stored fields 0, ready_d=1, valid_d=0. Decoded outputs then reflect instr=0 gated to 0 (all control outputs 0, illegal_d=0 while invalid).
- Latency: an instruction accepted at edge N is presented on the outputs during cycle N+1.
- Main register:
  - Empty, or emptying this cycle: loads from the skid register if the skid is valid, otherwise from the input.
  - Full and ready_e=0: an input transfer goes to the skid register.
- ready_d = ~skid_valid (registered). Once the skid is full, the next ready_e drains it into main, and ready_d returns to 1 the following cycle.
- Stall (ready_e=0): all outputs hold bit-stable.
- flush_d: at the next edge both valid bits clear and ready_d=1. It has priority over any simultaneous input or output transfer; the incoming instruction is dropped.
- Outputs are decoded combinationally from the main register. Every control output is forced to 0 when valid_d=0. Register fields and PCs pass through.
- Immediate by type:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All types sign-extended to XLEN.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
  - Branches use SUB.
  - lui uses PASSB.
  - auipc and jal use ADD.
- illegal_d is asserted for any opcode outside RV32I base, or an invalid funct7 on R-type/shift. It also forces reg_write_d and mem_write_d to 0.

Decomposition:
- Package decode_pkg: opcode constants, imm_src_t enum (IMM_I/S/B/U/J), alu_ctrl_t enum, result_src_t enum.
- Sub-module decode_ctrl: purely combinational; instr in, control signals and imm_ext out. It is instantiated once on the main register.

Test Plan:
- Reset with valid_f=1 held → valid_d=0 and ready_d=1 after release; first instr 0x00510093 (addi x1,x2,5) → next cycle valid_d=1, rs1=2, rd=1, imm=5, alu=ADD, alu_src=1, reg_write=1.
- Back-to-back 0x402081B3 (sub), 0x00512423 (sw x5,8(x2)) with ready_e=1 → one per cycle; sub: alu=SUB, alu_src=0; sw: imm=8, mem_write=1, reg_write=0.
- Stream 0xFE000EE3 (beq -4) then 0x123452B7 (lui x5,0x12345), ready_e=0 for 3 cycles → beq held stable, lui in skid, ready_d=0.
  - Release → beq (imm=0xFFFFFFFC, branch=1) then lui (imm=0x12345000, alu=PASSB), with no loss or duplication.
- flush_d asserted with skid full and valid_f=1 → next cycle valid_d=0, ready_d=1, and neither the held nor the incoming instruction appears.
- 0x008000EF (jal x1,8) → jump=1, imm=8, result_src=10; 0x00000000 → illegal_d=1, reg_write=0, mem_write=0.
- Assert reset mid-stream with skid full → valid_d and ready_d go to 0 and 1 immediately (asynchronous), before the next clock edge.
